// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory port between instruction fetch (IF)
// and the load/store unit (LSU), with one transaction outstanding at a time.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   if_req_i/adr_i     IF read request and word address (held until gnt)
//   if_gnt_o           IF request accepted by memory this cycle
//   if_rvalid_o/rdata  IF response
//   lsu_req_i ...      LSU request, address, we, wdata, size (held to gnt)
//   lsu_gnt_o          LSU request accepted this cycle
//   lsu_rvalid_o/rdata LSU response (load data or store ack)
//   mem_*_o            bus request channel toward memory
//   mem_gnt_i          bus accepted the request this cycle
//   mem_rvalid_i/rdata bus response
//   bus_err_o          one-cycle pulse when a response times out
module mem_arbiter #(
  parameter int XLEN           = 32,
  parameter int MAX_LSU_STREAK = 4,
  parameter int RSP_TIMEOUT    = 64
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_adr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,

  input  logic            lsu_req_i,
  input  logic [XLEN-1:0] lsu_adr_i,
  input  logic            lsu_we_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  input  logic [2:0]      lsu_size_i,
  output logic            lsu_gnt_o,
  output logic            lsu_rvalid_o,
  output logic [XLEN-1:0] lsu_rdata_o,

  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_adr_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [2:0]      mem_size_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,

  output logic            bus_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_GNT,
    S_WAIT_RSP
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_LSU_STREAK);
  localparam logic [7:0] TMO_LAST   = 8'(RSP_TIMEOUT - 1);
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [3:0] streak_q, streak_d;
  logic [7:0] timer_q, timer_d;

  logic win_lsu;
  logic sel_lsu;
  logic any_req;
  logic req;
  logic gnt;
  logic rsp;
  logic tmo;
  logic live;

  assign any_req = if_req_i | lsu_req_i;
  assign live    = ~reset;

  // LSU has priority unless IF has been passed over MAX_LSU_STREAK times.
  always_comb begin
    win_lsu = 1'b0;
    unique case (1'b1)
      (lsu_req_i && !if_req_i):
        win_lsu = 1'b1;
      (lsu_req_i && if_req_i):
        win_lsu = (streak_q != STREAK_MAX);
      default:
        win_lsu = 1'b0;
    endcase
  end

  // Only IDLE arbitrates live; afterwards the latched owner steers the bus.
  assign sel_lsu = (state_q == S_IDLE) ? win_lsu
                 : (owner_q == OWN_LSU);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    timer_d  = timer_q;
    req      = 1'b0;
    gnt      = 1'b0;
    rsp      = 1'b0;
    tmo      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          req     = 1'b1;
          owner_d = win_lsu ? OWN_LSU : OWN_IF;
          if (mem_gnt_i) begin
            gnt     = 1'b1;
            timer_d = '0;
            state_d = S_WAIT_RSP;
          end else begin
            state_d = S_WAIT_GNT;
          end
        end
      end
      S_WAIT_GNT: begin
        req = 1'b1;
        if (mem_gnt_i) begin
          gnt     = 1'b1;
          timer_d = '0;
          state_d = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        timer_d = timer_q + 8'd1;
        if (mem_rvalid_i) begin
          rsp     = 1'b1;
          state_d = S_IDLE;
        end else if (timer_q == TMO_LAST) begin
          rsp     = 1'b1;
          tmo     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The streak only counts LSU wins that actually kept IF waiting.
    if (gnt) begin
      if (sel_lsu && if_req_i) begin
        if (streak_q != STREAK_MAX) begin
          streak_d = streak_q + 4'd1;
        end
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_IF;
      streak_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      timer_q  <= timer_d;
    end
  end

  logic mreq;
  assign mreq = live & req;

  assign mem_req_o = mreq;

  always_comb begin
    mem_adr_o   = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_size_o  = '0;
    if (mreq) begin
      if (sel_lsu) begin
        mem_adr_o   = lsu_adr_i;
        mem_we_o    = lsu_we_i;
        mem_wdata_o = lsu_wdata_i;
        mem_size_o  = lsu_size_i;
      end else begin
        mem_adr_o   = if_adr_i;
        mem_size_o  = SIZE_WORD;
      end
    end
  end

  assign if_gnt_o  = live & gnt & ~sel_lsu;
  assign lsu_gnt_o = live & gnt & sel_lsu;

  logic rsp_if;
  logic rsp_lsu;

  assign rsp_if  = live & rsp & (owner_q == OWN_IF);
  assign rsp_lsu = live & rsp & (owner_q == OWN_LSU);

  assign if_rvalid_o  = rsp_if;
  assign lsu_rvalid_o = rsp_lsu;

  // A timed-out response carries zero data rather than whatever is on the bus.
  assign if_rdata_o  = (rsp_if && !tmo) ? mem_rdata_i : '0;
  assign lsu_rdata_o = (rsp_lsu && !tmo) ? mem_rdata_i : '0;

  assign bus_err_o = live & tmo;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// Scenario tasks drive the bus; expected responses go through a queue.
module tb_mem_arbiter;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            if_req_i;
  logic [XLEN-1:0] if_adr_i;
  logic            if_gnt_o;
  logic            if_rvalid_o;
  logic [XLEN-1:0] if_rdata_o;
  logic            lsu_req_i;
  logic [XLEN-1:0] lsu_adr_i;
  logic            lsu_we_i;
  logic [XLEN-1:0] lsu_wdata_i;
  logic [2:0]      lsu_size_i;
  logic            lsu_gnt_o;
  logic            lsu_rvalid_o;
  logic [XLEN-1:0] lsu_rdata_o;
  logic            mem_req_o;
  logic [XLEN-1:0] mem_adr_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [2:0]      mem_size_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;
  logic            bus_err_o;

  mem_arbiter #(
    .XLEN          (XLEN),
    .MAX_LSU_STREAK(4),
    .RSP_TIMEOUT   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req_i    (if_req_i),
    .if_adr_i    (if_adr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .lsu_req_i   (lsu_req_i),
    .lsu_adr_i   (lsu_adr_i),
    .lsu_we_i    (lsu_we_i),
    .lsu_wdata_i (lsu_wdata_i),
    .lsu_size_i  (lsu_size_i),
    .lsu_gnt_o   (lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o),
    .lsu_rdata_o (lsu_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_adr_o   (mem_adr_o),
    .mem_we_o    (mem_we_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_size_o  (mem_size_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .bus_err_o   (bus_err_o)
  );

  typedef struct packed {
    logic        lsu;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb[$];
  rsp_t exp;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester protocol monitor: req and attributes stable until gnt.
  logic            pend_if, pend_lsu;
  logic [XLEN-1:0] p_if_adr, p_lsu_adr, p_lsu_wd;
  logic            p_lsu_we;

  always @(posedge clk) begin
    if (reset) begin
      pend_if  <= 1'b0;
      pend_lsu <= 1'b0;
    end else begin
      if (pend_if && (!if_req_i || if_adr_i !== p_if_adr)) begin
        errors++;
        $display("FAIL if_protocol: req=%b adr=%h want held adr %h",
                 if_req_i, if_adr_i, p_if_adr);
      end
      if (pend_lsu && (!lsu_req_i || lsu_adr_i !== p_lsu_adr ||
          lsu_we_i !== p_lsu_we || lsu_wdata_i !== p_lsu_wd)) begin
        errors++;
        $display("FAIL lsu_protocol: req=%b adr=%h want held adr %h",
                 lsu_req_i, lsu_adr_i, p_lsu_adr);
      end
      pend_if   <= if_req_i && !if_gnt_o;
      pend_lsu  <= lsu_req_i && !lsu_gnt_o;
      p_if_adr  <= if_adr_i;
      p_lsu_adr <= lsu_adr_i;
      p_lsu_we  <= lsu_we_i;
      p_lsu_wd  <= lsu_wdata_i;
    end
  end

  task automatic idle_in();
    if_req_i     = 1'b0;
    if_adr_i     = '0;
    lsu_req_i    = 1'b0;
    lsu_adr_i    = '0;
    lsu_we_i     = 1'b0;
    lsu_wdata_i  = '0;
    lsu_size_i   = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  task automatic test_reset();
    logic [5:0] ctl;
    @(negedge clk);
    reset        = 1'b1;
    if_req_i     = 1'b1;
    if_adr_i     = 32'h44;
    lsu_req_i    = 1'b1;
    lsu_adr_i    = 32'h88;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hFFFF_FFFF;
    #1;
    ctl = {mem_req_o, if_gnt_o, lsu_gnt_o,
           if_rvalid_o, lsu_rvalid_o, bus_err_o};
    checks++;
    if (ctl !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 000000", ctl);
    end
    checks++;
    if (mem_adr_o !== 32'h0 || mem_size_o !== 3'b0) begin
      errors++;
      $display("FAIL reset_bus: got adr %h size %b want 0",
               mem_adr_o, mem_size_o);
    end
    checks++;
    if (if_rdata_o !== 32'h0 || lsu_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h want 0",
               if_rdata_o, lsu_rdata_o);
    end
    @(negedge clk);
    reset = 1'b0;
    idle_in();
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || if_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got req %b rvalid %b want 0",
               mem_req_o, if_rvalid_o);
    end
  endtask

  task automatic test_if_fetch();
    @(negedge clk);
    if_req_i  = 1'b1;
    if_adr_i  = 32'h100;
    mem_gnt_i = 1'b1;
    sb.push_back('{lsu: 1'b0, err: 1'b0, data: 32'hDEADBEEF});
    #1;
    checks++;
    if (mem_req_o !== 1'b1 || mem_adr_o !== 32'h100) begin
      errors++;
      $display("FAIL fetch_req: got req %b adr %h want 1 100",
               mem_req_o, mem_adr_o);
    end
    checks++;
    if (mem_we_o !== 1'b0 || mem_size_o !== 3'b010 ||
        mem_wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL fetch_attr: got we %b size %b wd %h want 0 010 0",
               mem_we_o, mem_size_o, mem_wdata_o);
    end
    checks++;
    if (if_gnt_o !== 1'b1 || lsu_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_gnt: got if %b lsu %b want 1 0",
               if_gnt_o, lsu_gnt_o);
    end
    @(negedge clk);
    if_req_i     = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEADBEEF;
    #1;
    exp = sb.pop_front();
    checks++;
    if (if_rvalid_o !== 1'b1 || if_rdata_o !== exp.data) begin
      errors++;
      $display("FAIL fetch_rsp: got %b %h want 1 %h",
               if_rvalid_o, if_rdata_o, exp.data);
    end
    checks++;
    if (lsu_rvalid_o !== 1'b0 || lsu_rdata_o !== 32'h0 ||
        bus_err_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_other: got lsu %b %h err %b want 0 0 0",
               lsu_rvalid_o, lsu_rdata_o, bus_err_o);
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_lsu_store();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      lsu_req_i   = 1'b1;
      lsu_adr_i   = 32'h2004;
      lsu_we_i    = 1'b1;
      lsu_wdata_i = 32'h55;
      lsu_size_i  = 3'b010;
      mem_gnt_i   = (k == 3);
      if (k == 3) sb.push_back('{lsu: 1'b1, err: 1'b0, data: 32'h0});
      #1;
      checks++;
      if (mem_req_o !== 1'b1 || mem_adr_o !== 32'h2004 ||
          mem_we_o !== 1'b1 || mem_wdata_o !== 32'h55 ||
          mem_size_o !== 3'b010) begin
        errors++;
        $display("FAIL store_hold%0d: got %b %h %b %h %b",
                 k, mem_req_o, mem_adr_o, mem_we_o,
                 mem_wdata_o, mem_size_o);
      end
      checks++;
      if (lsu_gnt_o !== (k == 3) || if_gnt_o !== 1'b0) begin
        errors++;
        $display("FAIL store_gnt%0d: got %b want %b",
                 k, lsu_gnt_o, (k == 3));
      end
    end
    @(negedge clk);
    lsu_req_i    = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0;
    #1;
    exp = sb.pop_front();
    checks++;
    if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== exp.data ||
        if_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL store_ack: got lsu %b %h if %b want 1 %h 0",
               lsu_rvalid_o, lsu_rdata_o, if_rvalid_o, exp.data);
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_no_rearb();
    @(negedge clk);
    if_req_i = 1'b1;
    if_adr_i = 32'h40;
    #1;
    checks++;
    if (mem_req_o !== 1'b1 || mem_adr_o !== 32'h40 ||
        if_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL rearb_c1: got %b %h %b want 1 40 0",
               mem_req_o, mem_adr_o, if_gnt_o);
    end
    @(negedge clk);
    lsu_req_i    = 1'b1;
    lsu_adr_i    = 32'h3000;
    lsu_size_i   = 3'b000;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h999;
    #1;
    checks++;
    if (mem_adr_o !== 32'h40 || mem_size_o !== 3'b010 ||
        lsu_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL rearb_hold: got %h %b %b want 40 010 0",
               mem_adr_o, mem_size_o, lsu_gnt_o);
    end
    checks++;
    if (if_rvalid_o !== 1'b0 || lsu_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL stale_rvalid: got %b %b want 0 0",
               if_rvalid_o, lsu_rvalid_o);
    end
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    mem_gnt_i    = 1'b1;
    sb.push_back('{lsu: 1'b0, err: 1'b0, data: 32'h1111_2222});
    #1;
    checks++;
    if (if_gnt_o !== 1'b1 || lsu_gnt_o !== 1'b0 ||
        mem_adr_o !== 32'h40) begin
      errors++;
      $display("FAIL rearb_gnt: got %b %b %h want 1 0 40",
               if_gnt_o, lsu_gnt_o, mem_adr_o);
    end
    @(negedge clk);
    if_req_i     = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1111_2222;
    #1;
    exp = sb.pop_front();
    checks++;
    if (if_rvalid_o !== 1'b1 || if_rdata_o !== exp.data ||
        lsu_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL rearb_rsp: got %b %h %b want 1 %h 0",
               if_rvalid_o, if_rdata_o, lsu_rvalid_o, exp.data);
    end
    checks++;
    if (mem_req_o !== 1'b0 || lsu_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL rsp_no_gnt: got req %b gnt %b want 0 0",
               mem_req_o, lsu_gnt_o);
    end
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    sb.push_back('{lsu: 1'b1, err: 1'b0, data: 32'h3333_4444});
    #1;
    checks++;
    if (lsu_gnt_o !== 1'b1 || mem_adr_o !== 32'h3000 ||
        mem_size_o !== 3'b000) begin
      errors++;
      $display("FAIL b2b_gnt: got %b %h %b want 1 3000 000",
               lsu_gnt_o, mem_adr_o, mem_size_o);
    end
    @(negedge clk);
    lsu_req_i    = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h3333_4444;
    #1;
    exp = sb.pop_front();
    checks++;
    if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== exp.data) begin
      errors++;
      $display("FAIL b2b_rsp: got %b %h want 1 %h",
               lsu_rvalid_o, lsu_rdata_o, exp.data);
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_starvation();
    logic el;
    logic [31:0] d;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if_req_i     = 1'b1;
      if_adr_i     = 32'h200;
      lsu_req_i    = 1'b1;
      lsu_adr_i    = 32'h3008;
      lsu_size_i   = 3'b010;
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = 1'b0;
      el = ((i % 5) != 4);
      d  = 32'hA000_0000 + 32'(i);
      sb.push_back('{lsu: el, err: 1'b0, data: d});
      #1;
      checks++;
      if (lsu_gnt_o !== el || if_gnt_o !== !el ||
          mem_adr_o !== (el ? 32'h3008 : 32'h200)) begin
        errors++;
        $display("FAIL starve_gnt%0d: got lsu %b if %b adr %h want lsu %b",
                 i, lsu_gnt_o, if_gnt_o, mem_adr_o, el);
      end
      @(negedge clk);
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = d;
      if (i == 9) if_req_i = 1'b0;
      #1;
      exp = sb.pop_front();
      checks++;
      if (lsu_rvalid_o !== exp.lsu || if_rvalid_o !== !exp.lsu ||
          (exp.lsu ? lsu_rdata_o : if_rdata_o) !== exp.data ||
          mem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL starve_rsp%0d: got lsu %b if %b req %b want lsu %b",
                 i, lsu_rvalid_o, if_rvalid_o, mem_req_o, exp.lsu);
      end
    end
    @(negedge clk);
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b0;
    sb.push_back('{lsu: 1'b1, err: 1'b0, data: 32'h5A5A_0001});
    #1;
    checks++;
    if (lsu_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL starve_tail: got lsu %b if %b want 1 0",
               lsu_gnt_o, if_gnt_o);
    end
    @(negedge clk);
    lsu_req_i    = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h5A5A_0001;
    #1;
    exp = sb.pop_front();
    checks++;
    if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== exp.data) begin
      errors++;
      $display("FAIL starve_tail_rsp: got %b %h want 1 %h",
               lsu_rvalid_o, lsu_rdata_o, exp.data);
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_timeout(input logic rv_on_tmo);
    @(negedge clk);
    lsu_req_i  = 1'b1;
    lsu_adr_i  = 32'h500;
    lsu_size_i = 3'b010;
    mem_gnt_i  = 1'b1;
    sb.push_back('{lsu: 1'b1, err: !rv_on_tmo,
                   data: rv_on_tmo ? 32'hCAFE_0001 : 32'h0});
    #1;
    checks++;
    if (lsu_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL tmo_gnt: got %b want 1", lsu_gnt_o);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      lsu_req_i    = 1'b0;
      mem_gnt_i    = 1'b0;
      mem_rdata_i  = 32'hBAD0_0000 | 32'(k);
      mem_rvalid_i = (k == 8) && rv_on_tmo;
      if (k == 8 && rv_on_tmo) mem_rdata_i = 32'hCAFE_0001;
      #1;
      if (k < 8) begin
        checks++;
        if (bus_err_o !== 1'b0 || lsu_rvalid_o !== 1'b0 ||
            if_rvalid_o !== 1'b0) begin
          errors++;
          $display("FAIL tmo_early%0d: got err %b rv %b want 0 0",
                   k, bus_err_o, lsu_rvalid_o);
        end
      end else begin
        exp = sb.pop_front();
        checks++;
        if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== exp.data ||
            bus_err_o !== exp.err || if_rvalid_o !== 1'b0) begin
          errors++;
          $display("FAIL tmo_fire: got rv %b d %h err %b want 1 %h %b",
                   lsu_rvalid_o, lsu_rdata_o, bus_err_o,
                   exp.data, exp.err);
        end
      end
    end
    @(negedge clk);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1234;
    #1;
    checks++;
    if (lsu_rvalid_o !== 1'b0 || if_rvalid_o !== 1'b0 ||
        bus_err_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_late: got %b %b %b want 0 0 0",
               lsu_rvalid_o, if_rvalid_o, bus_err_o);
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_reset_mid_rsp();
    @(negedge clk);
    if_req_i  = 1'b1;
    if_adr_i  = 32'h600;
    mem_gnt_i = 1'b1;
    #1;
    checks++;
    if (if_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_gnt: got %b want 1", if_gnt_o);
    end
    @(negedge clk);
    if_req_i  = 1'b0;
    mem_gnt_i = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset        = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h777;
    #1;
    checks++;
    if (if_rvalid_o !== 1'b0 || lsu_rvalid_o !== 1'b0 ||
        mem_req_o !== 1'b0 || bus_err_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_drop: got %b %b %b %b want 0 0 0 0",
               if_rvalid_o, lsu_rvalid_o, mem_req_o, bus_err_o);
    end
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    if_req_i     = 1'b1;
    if_adr_i     = 32'h604;
    mem_gnt_i    = 1'b1;
    sb.push_back('{lsu: 1'b0, err: 1'b0, data: 32'h88});
    #1;
    checks++;
    if (if_gnt_o !== 1'b1 || mem_adr_o !== 32'h604) begin
      errors++;
      $display("FAIL mid_regnt: got %b %h want 1 604",
               if_gnt_o, mem_adr_o);
    end
    @(negedge clk);
    if_req_i     = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h88;
    #1;
    exp = sb.pop_front();
    checks++;
    if (if_rvalid_o !== 1'b1 || if_rdata_o !== exp.data) begin
      errors++;
      $display("FAIL mid_rsp: got %b %h want 1 %h",
               if_rvalid_o, if_rdata_o, exp.data);
    end
    @(negedge clk);
    idle_in();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_in();
    repeat (2) @(negedge clk);
    test_reset();
    test_if_fetch();
    test_lsu_store();
    test_no_rearb();
    test_starvation();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_rsp();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single memory port between the instruction-fetch requester (IF) and the execute-stage load/store unit (LSU). It arbitrates with fixed LSU priority and an anti-starvation streak limit for IF, and tracks one outstanding transaction. Memory responses are routed back to the requester that owns the transaction, and a response timeout is detected and reported. It sits between the fetch and exe stages on one side and the memory bus on the other.

## Interface
Parameters:
- XLEN, 32, data/address width
- MAX_LSU_STREAK, 4, consecutive LSU grants allowed while IF is waiting (range 1..15)
- RSP_TIMEOUT, 64, cycles in WAIT_RSP before a timeout fires (range 2..255)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset; one clock, reset is synchronous and active-high
- if_req_i  in  1  IF read request; held with address until if_gnt_o
- if_adr_i  in  XLEN  IF word address
- if_gnt_o  out  1  IF request accepted by memory this cycle
- if_rvalid_o  out  1  IF response valid
- if_rdata_o  out  XLEN  IF response data
- lsu_req_i  in  1  LSU request; held with all attributes until lsu_gnt_o
- lsu_adr_i  in  XLEN  LSU byte address
- lsu_we_i  in  1  1 = store
- lsu_wdata_i  in  XLEN  store data
- lsu_size_i  in  3  access size, passed through unchanged
- lsu_gnt_o  out  1  LSU request accepted this cycle
- lsu_rvalid_o  out  1  LSU response valid (load data or store ack)
- lsu_rdata_o  out  XLEN  LSU response data
- mem_req_o  out  1  bus request
- mem_adr_o  out  XLEN  bus address
- mem_we_o  out  1  bus write enable (0 for IF)
- mem_wdata_o  out  XLEN  bus write data (0 for IF)
- mem_size_o  out  3  bus access size (3'b010 word for IF)
- mem_gnt_i  in  1  bus accepted the request this cycle
- mem_rvalid_i  in  1  bus response valid
- mem_rdata_i  in  XLEN  bus response data
- bus_err_o  out  1  one-cycle pulse on response timeout

## Operation
- State machine: IDLE, WAIT_GNT, WAIT_RSP. The registered `owner` field (IF/LSU) selects the mem_* mux and the response routing.
- IDLE, at least one request: select a winner combinationally, set mem_req_o=1, and drive the winner's attributes.
  - mem_gnt_i=1: assert the winner's gnt_o, latch owner, go to WAIT_RSP.
  - mem_gnt_i=0: latch owner, go to WAIT_GNT.
- WAIT_GNT: mem_req_o=1 with the owner's live inputs; no re-arbitration. On mem_gnt_i, assert the owner's gnt_o and go to WAIT_RSP.
- WAIT_RSP: mem_req_o=0; the timer increments each cycle.
  - mem_rvalid_i=1: owner's rvalid_o=1, rdata_o=mem_rdata_i; go to IDLE.
  - timer reaches RSP_TIMEOUT-1 without rvalid: bus_err_o=1, owner's rvalid_o=1 with rdata_o=0; go to IDLE.
  - Timer clears on entry to WAIT_RSP.
- Arbitration when both request: LSU wins unless streak==MAX_LSU_STREAK, in which case IF wins.
- Streak counter, updated at a grant:
  - LSU granted while if_req_i=1: increment, saturating.
  - LSU granted while if_req_i=0: clear to 0.
  - IF granted: clear to 0.
- The non-owner's gnt_o and rvalid_o stay 0. Its rdata_o is 0 at all times.
- mem_rvalid_i in IDLE or WAIT_GNT is stale: drop it, route nothing.
- rvalid and timeout in the same cycle: rvalid wins, bus_err_o=0.
- Requester protocol: req and attributes stay stable from assertion until gnt. A violation is a bench assertion failure; the arbiter does not handle it.

## Timing
- While reset=1, all outputs are 0 in that cycle. On the next edge: state=IDLE, owner=IF, streak=0, timer=0.
- Reset mid-transaction abandons it: the next cycle is IDLE, and any late mem_rvalid_i is dropped.
- Request to mem_req_o: 0 cycles (combinational from IDLE).
- gnt_o is combinational from mem_gnt_i in the same cycle.
- rvalid_o and rdata_o are combinational pass-through of mem_rvalid_i and mem_rdata_i.
- Minimum transaction: grant in cycle N, response in N+1. The next grant is possible in N+2, giving at most one transaction per 2 cycles.
- Timeout fires in the RSP_TIMEOUT-th cycle of WAIT_RSP (cycle N+RSP_TIMEOUT after a grant in cycle N).

## Test plan
- Reset mid-WAIT_RSP: pulse reset one cycle, then drive mem_rvalid_i=1 next cycle -> no rvalid_o on either side; state IDLE; a new IF request is granted normally.
- Single IF fetch: if_req_i=1, if_adr_i=0x100, immediate mem_gnt_i, rdata 0xDEADBEEF one cycle later -> mem_adr_o=0x100, mem_we_o=0, mem_size_o=3'b010, if_gnt_o=1, then if_rvalid_o=1 with 0xDEADBEEF, lsu_rvalid_o=0.
- LSU store with gnt delay: lsu_we_i=1, adr 0x2004, wdata 0x55, mem_gnt_i low 3 cycles -> mem_req_o held 4 cycles with stable attributes; lsu_gnt_o on the 4th; the ack gives lsu_rvalid_o=1.
- Starvation, MAX_LSU_STREAK=4: IF and LSU request continuously, zero-wait memory -> grant order LSU, LSU, LSU, LSU, IF, repeating.
- Timeout, RSP_TIMEOUT=8: LSU load granted at cycle N, no rvalid -> cycle N+8: bus_err_o=1, lsu_rvalid_o=1, lsu_rdata_o=0; a rvalid at N+9 is dropped.
- Rvalid on the timeout cycle: rvalid at N+8 under the same setup -> bus_err_o=0, data delivered.
